// File: rtl/serial_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_stream_pkg
// Description : Shared state encoding and limits for serial_bit_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } ser_state_t;

  localparam int MAX_GAP = 15;

endpackage
`default_nettype wire

// File: rtl/serial_bit_streamer.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_streamer
// Description : Parallel-to-serial front end; WIDTH-bit words in over
//               valid/ready, one bit per clock out on ser_bit/ser_valid.
//               Optional macro SER_PARITY_EN appends an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_streamer
  import serial_stream_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int              CNT_W    = $clog2(FRAME + 1);
  localparam int              GAP_W    = $clog2(MAX_GAP + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit              HAS_GAP  = (GAP_CYCLES > 0);

  ser_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gcnt_q;
  logic [FRAME-1:0] sr_q;

  logic [FRAME-1:0] load_d;
  logic [FRAME-1:0] shift_d;
  logic             head;
  logic             frame_end;
  logic             accept;

  // The head of the shift register is always the bit on the wire this cycle.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign head    = sr_q[FRAME-1];
    assign shift_d = {sr_q[FRAME-2:0], 1'b0};
`ifdef SER_PARITY_EN
    assign load_d  = {in_data, ^in_data};
`else
    assign load_d  = in_data;
`endif
  end else begin : g_lsb_first
    assign head    = sr_q[0];
    assign shift_d = {1'b0, sr_q[FRAME-1:1]};
`ifdef SER_PARITY_EN
    assign load_d  = {^in_data, in_data};
`else
    assign load_d  = in_data;
`endif
  end

  assign frame_end = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);

  // Ready on the last frame bit (no gap) keeps back-to-back words bubble-free.
  assign in_ready = !rst && ((state_q == S_IDLE) ||
                             (frame_end && !HAS_GAP) ||
                             ((state_q == S_GAP) && (gcnt_q == GAP_LAST)));
  assign accept   = in_valid && in_ready;

  assign ser_valid = (state_q == S_SHIFT);
  assign ser_bit   = ser_valid && head;
  assign ser_last  = frame_end;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      sr_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_SHIFT;
            sr_q    <= load_d;
            cnt_q   <= '0;
          end
        end
        S_SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (accept) begin
              sr_q <= load_d;
            end else if (HAS_GAP) begin
              state_q <= S_GAP;
              gcnt_q  <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            sr_q  <= shift_d;
          end
        end
        S_GAP: begin
          if (gcnt_q == GAP_LAST) begin
            if (accept) begin
              state_q <= S_SHIFT;
              sr_q    <= load_d;
              cnt_q   <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_bit_streamer
// Description : Scoreboard bench; two configurations (MSB-first no gap,
//               LSB-first gap 2) against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bit_streamer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  typedef struct packed {
    int   cyc;
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cfg%0d cyc=%0d: got %0h expected %0h", name, g, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int MSB = (g == 0) ? 1 : 0;
    localparam int GAP = (g == 0) ? 0 : 2;

    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_ready, ser_bit, ser_valid, ser_last, busy;
    exp_t         q[$];
    int           last_acc = -1000;
    bit           done     = 1'b0;

    serial_bit_streamer #(.WIDTH(W), .MSB_FIRST(MSB), .GAP_CYCLES(GAP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ser_bit   (ser_bit),
      .ser_valid (ser_valid),
      .ser_last  (ser_last),
      .busy      (busy)
    );

    // A word accepted in cycle acc occupies cycles acc+1 .. acc+FRAME.
    task automatic push_frame(input logic [W-1:0] w, input int acc);
      exp_t e;
      for (int k = 0; k < FRAME; k++) begin
        e.cyc = acc + 1 + k;
        if (k < W) e.b = (MSB != 0) ? w[W-1-k] : w[k];
        else       e.b = ^w;
        e.last = (k == FRAME - 1);
        q.push_back(e);
      end
    endtask

    task automatic offer(input logic [W-1:0] w);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int t = 0; t < 200; t++) begin
        #1;
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!ok) begin
        check("accept_timeout", g, 0, 1);
      end else begin
        push_frame(w, cyc);
        @(posedge clk); #1;
        last_acc = cyc - 1;
      end
    endtask

    task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
        in_data = W'($urandom);
        @(posedge clk); #1;
      end
    endtask

    initial begin : drv
      logic [W-1:0] w;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      offer(8'hA5); idle(5);
      offer(8'h0A); offer(8'hA0); idle(3);
      offer(8'h01); idle(2);
      offer(8'hF0); offer(8'h3C); idle(4);
      // Reset during bit 3 of 8'hFF, then a fresh frame.
      offer(8'hFF);
      repeat (3) @(posedge clk);
      #3;
      in_valid = 1'b0;
      rst      = 1'b1;
      q.delete();
      last_acc = -1000;
      #1 check("async_rst_outputs", g, {27'd0, ser_valid, ser_bit, ser_last, busy, in_ready}, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      offer(8'h80); idle(6);
      for (int n = 0; n < 60; n++) begin
        w = W'($urandom);
        offer(w);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 12));
      end
      idle(FRAME + GAP + 4);
      check("leftover_expected_bits", g, q.size(), 0);
      done = 1'b1;
    end

    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst) begin
          check("reset_outputs", g, {27'd0, ser_valid, ser_bit, ser_last, busy, in_ready}, 0);
        end else begin
          check("in_ready", g, in_ready, (cyc >= last_acc + FRAME + GAP));
          check("busy", g, busy, (cyc > last_acc) && (cyc <= last_acc + FRAME + GAP));
          if (ser_valid) begin
            if (q.size() == 0) begin
              check("unexpected_ser_valid", g, 1, 0);
            end else begin
              e = q.pop_front();
              check("bit_cycle", g, cyc, e.cyc);
              check("ser_bit", g, ser_bit, e.b);
              check("ser_last", g, ser_last, e.last);
            end
          end else begin
            check("idle_bit_last", g, {ser_bit, ser_last}, 0);
            if (q.size() > 0 && q[0].cyc <= cyc) begin
              e = q.pop_front();
              check("missing_ser_valid", g, 0, 1);
            end
          end
        end
      end
    end
  end

  initial begin
    fork
      wait (g_cfg[0].done && g_cfg[1].done);
      begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected done");
        errs++;
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
